memory_port_arbiter: RTL

Shares one single-port `memory_block_interface` instance among `NUM_REQ` requesters, such as the digit-array engines and the result streamer. The arbiter issues at most one access per clock, either a read or a write. Grants rotate round-robin, and a lock lets a requester keep the port for read-modify-write sequences. Read data returns to the granted requester exactly one cycle after its grant.

---
 rtl/memory_arbiter_pkg.sv | 6 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/memory_port_arbiter.sv | 68 ++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared state type and default widths for the memory port arbiter
package memory_arbiter_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: one-hot round-robin pick of the first request above last, wrapping
module rr_priority_picker #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        idx = IW'(i);
      end
    for (int i = N - 1; i >= 0; i--)
      if (req[i] && i > int'(last)) begin
        grant = '0;
        grant[i] = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin single-port memory arbiter with lock and lock watchdog
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          lock_error,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_write_input,
  output logic                          mem_write_enable,
  input  logic [DATA_WIDTH-1:0]         mem_read_output
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  arb_state_t state, state_n;
  logic [IW-1:0] owner, last, idx;
  logic [CW-1:0] idle_cnt;
  logic [NUM_REQ-1:0] grant;
  logic any, owner_idle, timeout;
  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req(state == ARB_LOCKED ? req_valid & (NUM_REQ'(1) << owner) : req_valid),
    .last(last),
    .grant(grant),
    .idx(idx)
  );
  assign rsp_data = mem_read_output;
  always_comb begin
    any = |grant;
    owner_idle = state == ARB_LOCKED && !req_valid[owner];
    timeout = owner_idle && idle_cnt == CW'(LOCK_TIMEOUT);
    state_n = state == ARB_IDLE ? (any && req_lock[idx] ? ARB_LOCKED : ARB_IDLE)
                                : (timeout || (any && !req_lock[idx]) ? ARB_IDLE : ARB_LOCKED);
    req_ready = grant;
    lock_error = timeout;
    mem_address = any ? req_address[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_write_input = any ? req_wdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    mem_write_enable = any && req_write[idx];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= ARB_IDLE;
      owner <= '0;
      last <= IW'(NUM_REQ - 1);
      idle_cnt <= '0;
      rsp_valid <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= any && !req_write[idx] ? grant : '0;
      if (any) begin
        last <= idx;
        owner <= idx;
      end
      idle_cnt <= any || timeout ? '0 : owner_idle ? idle_cnt + CW'(1) : idle_cnt;
    end
endmodule
